// File: rtl/audio_eq_pkg.sv
// rtl/audio_eq_pkg.sv - shared types and constants for the audio equalizer front end
package audio_eq_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } i2s_state_t;

    localparam int I2S_SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_edge_sync.sv
// rtl/i2s_edge_sync.sv - synchroniser for one async I2S line with registered rise detect
module i2s_edge_sync
    import audio_eq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [I2S_SYNC_STAGES-1:0] sync_q;
    logic                       prev_q;
    logic                       rise_q;

    // level_o is delayed one stage so it lines up with rise_o on every instance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[I2S_SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[I2S_SYNC_STAGES-1];
            rise_q <= sync_q[I2S_SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/i2s_sample_rx.sv
// rtl/i2s_sample_rx.sv - I2S slave receiver, one signed PCM word per frame; I2S_RX_MONO_MIX_EN selects L/R average
module i2s_sample_rx
    import audio_eq_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32,
    parameter int CHANNEL  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_bclk,
    input  logic                i_lrclk,
    input  logic                i_sdata,
    output logic                o_cs,
    output logic [SAMPLE_W-1:0] o_sample,
    output logic                o_frame_err
);

    localparam int BIT_CW  = $clog2(SAMPLE_W);
    localparam int SLOT_CW = $clog2(SLOT_W + 1);

    logic brise;
    logic lr_s;
    logic sd_s;
    logic unused_rise;
    logic lr_rise;
    logic sd_rise;

    i2s_edge_sync u_sync_bclk  (.clk(clk), .rst_n(rst_n), .d_i(i_bclk),  .level_o(unused_rise), .rise_o(brise));
    i2s_edge_sync u_sync_lrclk (.clk(clk), .rst_n(rst_n), .d_i(i_lrclk), .level_o(lr_s),        .rise_o(lr_rise));
    i2s_edge_sync u_sync_sdata (.clk(clk), .rst_n(rst_n), .d_i(i_sdata), .level_o(sd_s),        .rise_o(sd_rise));

    logic unused_ok;
    assign unused_ok = ^{unused_rise, lr_rise, sd_rise};

    i2s_state_t            state_q, state_d;
    logic [BIT_CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SLOT_CW-1:0]    slot_cnt_q, slot_cnt_d;
    logic [SAMPLE_W-1:0]   shift_q, shift_d;
    logic                  lr_prev_q, lr_prev_d;
    logic                  chan_q, chan_d;
    logic                  cs_q, cs_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic                  err_q, err_d;

    logic                  lr_edge;
    logic                  word_done;
    logic                  frame_err;
    logic [SAMPLE_W-1:0]   word;

    assign lr_edge = brise & (lr_s != lr_prev_q);
    assign word    = {shift_q[SAMPLE_W-2:0], sd_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        slot_cnt_d = slot_cnt_q;
        shift_d    = shift_q;
        lr_prev_d  = lr_prev_q;
        chan_d     = chan_q;
        word_done  = 1'b0;
        frame_err  = 1'b0;

        if (brise) begin
            lr_prev_d = lr_s;
            if (state_q != IDLE) begin
                slot_cnt_d = slot_cnt_q + 1'b1;
            end
            // slot_cnt counts the edge brise as the slot's first BCLK
            if (lr_edge) begin
                slot_cnt_d = SLOT_CW'(1);
                chan_d     = lr_s;
            end

            case (state_q)
                IDLE: begin
                    if (lr_edge) begin
                        state_d = SKIP;
                    end
                end
                SKIP: begin
                    if (lr_edge) begin
                        frame_err = 1'b1;
                    end else begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                SHIFT: begin
                    if (lr_edge) begin
                        frame_err = 1'b1;
                        state_d   = SKIP;
                    end else begin
                        shift_d = word;
                        if (bit_cnt_q == BIT_CW'(SAMPLE_W - 1)) begin
                            word_done = 1'b1;
                            state_d   = PAD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (lr_edge) begin
                        state_d = SKIP;
                    end else if (slot_cnt_q == SLOT_CW'(SLOT_W)) begin
                        frame_err = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef I2S_RX_MONO_MIX_EN
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
    logic                hold_vld_q, hold_vld_d;
    logic [SAMPLE_W:0]   mix_sum;

    // one extra bit keeps the sum exact; dropping bit 0 is the arithmetic halving
    assign mix_sum = {hold_l_q[SAMPLE_W-1], hold_l_q} + {word[SAMPLE_W-1], word};

    always_comb begin
        cs_d       = 1'b0;
        err_d      = frame_err;
        sample_d   = sample_q;
        hold_l_d   = hold_l_q;
        hold_vld_d = hold_vld_q;
        if (frame_err) begin
            hold_l_d   = '0;
            hold_vld_d = 1'b0;
        end else if (word_done) begin
            if (!chan_q) begin
                hold_l_d   = word;
                hold_vld_d = 1'b1;
            end else if (hold_vld_q) begin
                cs_d       = 1'b1;
                sample_d   = mix_sum[SAMPLE_W:1];
                hold_l_d   = '0;
                hold_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_l_q   <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_l_q   <= hold_l_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`else
    always_comb begin
        cs_d     = 1'b0;
        err_d    = frame_err;
        sample_d = sample_q;
        if (word_done && (chan_q == 1'(CHANNEL))) begin
            cs_d     = 1'b1;
            sample_d = word;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            slot_cnt_q <= '0;
            shift_q    <= '0;
            lr_prev_q  <= 1'b0;
            chan_q     <= 1'b0;
            cs_q       <= 1'b0;
            sample_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            shift_q    <= shift_d;
            lr_prev_q  <= lr_prev_d;
            chan_q     <= chan_d;
            cs_q       <= cs_d;
            sample_q   <= sample_d;
            err_q      <= err_d;
        end
    end

    assign o_cs        = cs_q;
    assign o_sample    = sample_q;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// tb/tb_i2s_sample_rx.sv - directed self-checking bench for i2s_sample_rx
module tb_i2s_sample_rx;
    import audio_eq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_bclk;
    logic        i_lrclk;
    logic        i_sdata;
    logic        o_cs;
    logic [15:0] o_sample;
    logic        o_frame_err;

    i2s_sample_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_bclk     (i_bclk),
        .i_lrclk    (i_lrclk),
        .i_sdata    (i_sdata),
        .o_cs       (o_cs),
        .o_sample   (o_sample),
        .o_frame_err(o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          cyc = 0;
    int          cs_cnt = 0;
    int          err_cnt = 0;
    int          cs_cyc = 0;
    int          lsb_cyc = 0;
    logic [15:0] last_sample = 16'h0;
    logic        prev_cs = 1'b0;
    logic        mon_viol = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_cs) begin
                cs_cnt      <= cs_cnt + 1;
                last_sample <= o_sample;
                cs_cyc      <= cyc;
            end
            if (o_frame_err) err_cnt <= err_cnt + 1;
            if ((o_cs && o_frame_err) || (o_cs && prev_cs)) mon_viol <= 1'b1;
        end
        prev_cs <= o_cs;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // slot bit 0 carries the LR edge, bit 1 is the one-bit delay, bits 2..17 hold the word
    task automatic send_bits(input logic lr, input logic [15:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            i_bclk  = 1'b0;
            i_lrclk = lr;
            i_sdata = (i >= 2 && i <= 17) ? w[17-i] : 1'b0;
            tick(4);
            i_bclk = 1'b1;
            if (i == 17) lsb_cyc = cyc;
            tick(4);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        i_bclk  = 1'b0;
        i_lrclk = 1'b0;
        i_sdata = 1'b0;
        tick(5);
        chk("reset_cs", 32'(o_cs), 32'h0);
        chk("reset_sample", 32'(o_sample), 32'h0);
        chk("reset_err", 32'(o_frame_err), 32'h0);
        rst_n = 1'b1;
        tick(2);

`ifdef I2S_RX_MONO_MIX_EN
        send_bits(1'b1, 16'h0000, 0, 31);
        chk("mix_prime_cs", 32'(cs_cnt), 32'd0);
        send_bits(1'b0, 16'h7FFF, 0, 31);
        send_bits(1'b1, 16'h7FFF, 0, 31);
        chk("mix1_cs", 32'(cs_cnt), 32'd1);
        chk("mix1_sample", 32'(last_sample), 32'h7FFF);
        send_bits(1'b0, 16'h8000, 0, 31);
        send_bits(1'b1, 16'h7FFF, 0, 31);
        chk("mix2_cs", 32'(cs_cnt), 32'd2);
        chk("mix2_sample", 32'(last_sample), 32'hFFFF);
        chk("mix_err", 32'(err_cnt), 32'd0);
`else
        // priming right slot provides the first LR edge
        send_bits(1'b1, 16'h1234, 0, 31);
        chk("t1_prime_cs", 32'(cs_cnt), 32'd0);
        send_bits(1'b0, 16'h7FFF, 0, 31);
        send_bits(1'b1, 16'h1234, 0, 31);
        send_bits(1'b0, 16'h7FFF, 0, 31);
        send_bits(1'b1, 16'h1234, 0, 31);
        chk("t1_cs", 32'(cs_cnt), 32'd2);
        chk("t1_sample", 32'(last_sample), 32'h7FFF);
        chk("t1_err", 32'(err_cnt), 32'd0);

        send_bits(1'b0, 16'h8001, 0, 31);
        chk("t2_cs", 32'(cs_cnt), 32'd3);
        chk("t2_sample", 32'(last_sample), 32'h8001);
        chk("t2_latency", 32'(cs_cyc - lsb_cyc), 32'd4);
        send_bits(1'b1, 16'h0000, 0, 31);

        send_bits(1'b0, 16'hFFFF, 0, 9);
        send_bits(1'b1, 16'h1111, 0, 31);
        chk("t3_err", 32'(err_cnt), 32'd1);
        chk("t3_no_cs", 32'(cs_cnt), 32'd3);
        send_bits(1'b0, 16'h00A5, 0, 31);
        chk("t3_cs", 32'(cs_cnt), 32'd4);
        chk("t3_sample", 32'(last_sample), 32'h00A5);

        send_bits(1'b1, 16'h2222, 0, 39);
        chk("t4_err", 32'(err_cnt), 32'd2);
        chk("t4_no_cs", 32'(cs_cnt), 32'd4);
        chk("t4_state", 32'(dut.state_q), 32'(IDLE));
        send_bits(1'b0, 16'h3333, 0, 31);
        chk("t4_cs", 32'(cs_cnt), 32'd5);
        chk("t4_sample", 32'(last_sample), 32'h3333);

        send_bits(1'b1, 16'h0000, 0, 31);
        send_bits(1'b0, 16'h5555, 0, 7);
        rst_n = 1'b0;
        tick(3);
        chk("t5_rst_cs", 32'(o_cs), 32'h0);
        chk("t5_rst_sample", 32'(o_sample), 32'h0);
        chk("t5_rst_err", 32'(o_frame_err), 32'h0);
        rst_n = 1'b1;
        send_bits(1'b0, 16'h5555, 8, 31);
        send_bits(1'b1, 16'h6666, 0, 31);
        chk("t5_no_cs", 32'(cs_cnt), 32'd5);
        send_bits(1'b0, 16'h7777, 0, 31);
        chk("t5_cs", 32'(cs_cnt), 32'd6);
        chk("t5_sample", 32'(last_sample), 32'h7777);
        chk("t5_err", 32'(err_cnt), 32'd2);
`endif
        chk("strobe_rules", 32'(mon_viol), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
